// File: rtl/afifo_rd_stream_if.sv
// Read-side bundle of the dual-clock FIFO consumer: the FIFO read port plus the
// outgoing valid/ready stream. The master modport is the consumer block itself.
interface afifo_rd_stream_if #(
   parameter int WIDTH = 8
);
   logic             i_fifo_empty;
   logic             o_fifo_rd_en;
   logic [WIDTH-1:0] i_fifo_data;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_last;
   logic             i_ready;

   modport master (
      input  i_fifo_empty, i_fifo_data, i_ready,
      output o_fifo_rd_en, o_valid, o_data, o_last
   );

   modport slave (
      output i_fifo_empty, i_fifo_data, i_ready,
      input  o_fifo_rd_en, o_valid, o_data, o_last
   );
endinterface

// File: rtl/afifo_rd_stream.sv
// FIFO read-side consumer: pulls words into a 2-entry registered skid buffer and
// presents them as a valid/ready stream with optional fixed-length packet framing.
module afifo_rd_stream #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic [LEN_W-1:0] i_pkt_len,
   afifo_rd_stream_if.master bus,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pkt_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [LEN_W-1:0]       idx_q, idx_d;
   logic [LEN_W-1:0]       len_q, len_cur;
   logic [1:0][WIDTH-1:0]  data_q;
   logic [1:0]             last_q;
   logic                   rd_en;
   logic                   pop;
   logic                   tag_last;
   logic                   wr_slot;

   // Read issue depends on registered state only, never on downstream ready.
   always_comb begin
      rd_en = ((state_q == RUN) || (state_q == FINISH)) && !bus.i_fifo_empty && (cnt_q != 2'd2);
      pop   = (cnt_q != 2'd0) && bus.i_ready;
   end

   // The packet length is sampled only at the first word of a packet.
   always_comb begin
      len_cur  = (idx_q == '0) ? i_pkt_len : len_q;
      tag_last = (len_cur != '0) && (idx_q == (len_cur - LEN_W'(1)));
      idx_d    = idx_q;
      if (rd_en) begin
         idx_d = ((len_cur == '0) || tag_last) ? '0 : (idx_q + LEN_W'(1));
      end
      cnt_d   = cnt_q + {1'b0, rd_en} - {1'b0, pop};
      wr_slot = !((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
   end

   // The stop decision looks at the post-push index so a word pushed in the
   // same cycle is never stranded mid-packet.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_enable) state_d = RUN;
         RUN:     if (!i_enable) state_d = (idx_d == '0) ? IDLE : FINISH;
         FINISH:  if (rd_en && tag_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= 2'd0;
         idx_q     <= '0;
         len_q     <= '0;
         o_pkt_cnt <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (rd_en && (idx_q == '0)) len_q <= i_pkt_len;
         if (pop && last_q[0]) o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
      end
   end

   // Buffer payload carries no reset; the outputs are masked by the entry count.
   always_ff @(posedge i_clk) begin
      if (pop) begin
         data_q[0] <= data_q[1];
         last_q[0] <= last_q[1];
      end
      if (rd_en) begin
         data_q[wr_slot] <= bus.i_fifo_data;
         last_q[wr_slot] <= tag_last;
      end
   end

   always_comb begin
      bus.o_fifo_rd_en = rd_en;
      bus.o_valid      = (cnt_q != 2'd0);
      bus.o_data       = (cnt_q != 2'd0) ? data_q[0] : '0;
      bus.o_last       = (cnt_q != 2'd0) && last_q[0];
      o_busy           = (state_q != IDLE) || (cnt_q != 2'd0);
   end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream: a FIFO model feeds the block, and every
// written word's expected data/last tag is queued and compared at the stream side.
module tb_afifo_rd_stream;
   localparam int WIDTH = 8;
   localparam int LEN_W = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic [LEN_W-1:0] pkt_len;
   logic             busy;
   logic [CNT_W-1:0] pkt_cnt;
   logic             ready;
   logic             hold_empty;

   logic [WIDTH-1:0] mem [256];
   logic             exp_last [256];
   int wr_ptr, rd_ptr, out_ptr;
   int checks, errors;
   int cyc, n_reads, n_beats, first_rd, first_val, last_val, exp_pkt;
   int r, r2, n, changed;
   logic [WIDTH-1:0] hold;

   always #5 clk = ~clk;

   afifo_rd_stream_if #(.WIDTH(WIDTH)) sif ();

   afifo_rd_stream #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_enable  (enable),
      .i_pkt_len (pkt_len),
      .bus       (sif),
      .o_busy    (busy),
      .o_pkt_cnt (pkt_cnt)
   );

   assign sif.i_fifo_empty = (wr_ptr == rd_ptr) || hold_empty;
   assign sif.i_fifo_data  = (sif.o_fifo_rd_en && !sif.i_fifo_empty) ? mem[rd_ptr[7:0]] : '0;
   assign sif.i_ready      = ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [WIDTH-1:0] d, input logic l);
      mem[wr_ptr[7:0]]      = d;
      exp_last[wr_ptr[7:0]] = l;
      wr_ptr++;
   endtask

   // One clock: sample at the falling edge, advance the FIFO model after the rising edge.
   task automatic cycle();
      logic rd_now, emp_now;
      @(negedge clk);
      rd_now  = sif.o_fifo_rd_en;
      emp_now = sif.i_fifo_empty;
      if (rd_now) chk("rd_en_while_empty", emp_now, 1'b0);
      if (sif.o_valid && ready) begin
         chk("beat_expected", (out_ptr < wr_ptr), 1'b1);
         chk("beat_data", sif.o_data, mem[out_ptr[7:0]]);
         chk("beat_last", sif.o_last, exp_last[out_ptr[7:0]]);
         if (exp_last[out_ptr[7:0]]) exp_pkt++;
         if (first_val < 0) first_val = cyc;
         last_val = cyc;
         n_beats++;
         out_ptr++;
      end
      if (rd_now && first_rd < 0) first_rd = cyc;
      @(posedge clk);
      #1;
      if (rd_now && !emp_now) begin
         rd_ptr++;
         n_reads++;
      end
      cyc++;
   endtask

   task automatic drain(input string tag, input int tgt);
      int k;
      k = 0;
      while (out_ptr != tgt && k < 300) begin
         cycle();
         k++;
      end
      chk(tag, out_ptr, tgt);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; pkt_len = '0; ready = 1'b1; hold_empty = 1'b0;
      wr_ptr = 0; rd_ptr = 0; out_ptr = 0; checks = 0; errors = 0;
      cyc = 0; n_reads = 0; n_beats = 0; first_rd = -1; first_val = -1; last_val = 0; exp_pkt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en", sif.o_fifo_rd_en, 1'b0);
      chk("rst_valid", sif.o_valid, 1'b0);
      chk("rst_data", sif.o_data, 8'h00);
      chk("rst_last", sif.o_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pkt_cnt", pkt_cnt, 16'd0);
      rst = 1'b0;
      cycle();
      chk("post_rst_valid", sif.o_valid, 1'b0);
      chk("post_rst_rd_en", sif.o_fifo_rd_en, 1'b0);

      // Unframed streaming of 16 preloaded words
      for (int i = 1; i <= 16; i++) put(WIDTH'(i), 1'b0);
      cycle(); cycle();
      chk("idle_no_read", n_reads, 0);
      enable = 1'b1;
      drain("stream_drain", wr_ptr);
      chk("stream_latency", first_val - first_rd, 1);
      chk("stream_beats", n_beats, 16);
      chk("stream_back_to_back", last_val - first_val, 15);

      // Framing with 4-word packets, then single-word packets
      pkt_len = 8'd4;
      for (int i = 0; i < 12; i++) put(8'h20 + WIDTH'(i), (i % 4) == 3);
      drain("frame4_drain", wr_ptr);
      chk("frame4_pkt_cnt", pkt_cnt, 16'd3);
      pkt_len = 8'd1;
      for (int i = 0; i < 4; i++) put(8'h30 + WIDTH'(i), 1'b1);
      drain("frame1_drain", wr_ptr);
      chk("frame1_pkt_cnt", pkt_cnt, 16'd7);
      chk("frame_model_cnt", pkt_cnt, exp_pkt[CNT_W-1:0]);

      // Back-pressure: only two reads fill the buffer
      pkt_len = 8'd0;
      ready = 1'b0;
      r = n_reads;
      for (int i = 0; i < 6; i++) put(8'h40 + WIDTH'(i), 1'b0);
      cycle(); cycle();
      hold = sif.o_data;
      chk("bp_head", hold, 8'h40);
      cycle(); cycle(); cycle();
      chk("bp_reads", n_reads - r, 2);
      chk("bp_rd_en_low", sif.o_fifo_rd_en, 1'b0);
      chk("bp_valid", sif.o_valid, 1'b1);
      chk("bp_data_stable", sif.o_data, hold);
      ready = 1'b1;
      drain("bp_drain", wr_ptr);
      chk("bp_total_reads", n_reads - r, 6);

      // Reset with a full buffer and a nonzero packet count
      ready = 1'b0;
      r = n_reads;
      for (int i = 0; i < 4; i++) put(8'h50 + WIDTH'(i), 1'b0);
      cycle(); cycle(); cycle();
      chk("pre_rst_reads", n_reads - r, 2);
      chk("pre_rst_valid", sif.o_valid, 1'b1);
      rst = 1'b1;
      #1;
      out_ptr = rd_ptr;
      exp_pkt = 0;
      chk("mid_rst_valid", sif.o_valid, 1'b0);
      chk("mid_rst_rd_en", sif.o_fifo_rd_en, 1'b0);
      chk("mid_rst_pkt_cnt", pkt_cnt, 16'd0);
      chk("mid_rst_busy", busy, 1'b0);
      enable = 1'b0;
      cycle();
      rst = 1'b0;
      #1;
      chk("rel_valid", sif.o_valid, 1'b0);
      chk("rel_busy", busy, 1'b0);
      r = n_reads;
      repeat (5) cycle();
      chk("disabled_no_read", n_reads - r, 0);
      rd_ptr = wr_ptr;
      out_ptr = wr_ptr;
      ready = 1'b1;

      // Graceful stop mid-packet, then stop at a packet boundary
      pkt_len = 8'd4;
      enable = 1'b1;
      r = n_reads;
      put(8'h61, 1'b0); put(8'h62, 1'b0);
      n = 0;
      while (n_reads - r < 2 && n < 20) begin cycle(); n++; end
      chk("gs_two_reads", n_reads - r, 2);
      enable = 1'b0;
      put(8'h63, 1'b0); put(8'h64, 1'b1); put(8'h65, 1'b0); put(8'h66, 1'b0);
      cycle();
      chk("gs_busy_finish", busy, 1'b1);
      repeat (7) cycle();
      chk("gs_finish_reads", n_reads - r, 4);
      chk("gs_idle", busy, 1'b0);
      chk("gs_delivered", out_ptr, rd_ptr);
      put(8'h67, 1'b0); put(8'h68, 1'b1);
      enable = 1'b1;
      n = 0;
      while (n_reads - r < 8 && n < 20) begin cycle(); n++; end
      chk("gs_resume_reads", n_reads - r, 8);
      enable = 1'b0;
      cycle();
      r2 = n_reads;
      for (int i = 0; i < 4; i++) put(8'h70 + WIDTH'(i), 1'b0);
      repeat (6) cycle();
      chk("gs_boundary_no_read", n_reads - r2, 0);
      chk("gs_boundary_idle", busy, 1'b0);
      chk("gs_pkt_cnt", pkt_cnt, 16'd2);
      rd_ptr = wr_ptr;
      out_ptr = wr_ptr;

      // Sparse source with random stalls; length change inside the first packet
      pkt_len = 8'd3;
      r = n_reads;
      for (int i = 0; i < 13; i++) put(8'h80 + WIDTH'(i), (i == 2) || (i == 7) || (i == 12));
      enable = 1'b1;
      changed = 0;
      n = 0;
      while (out_ptr != wr_ptr && n < 400) begin
         hold_empty = 1'($urandom_range(0, 1));
         ready      = 1'($urandom_range(0, 1));
         if (changed == 0 && n_reads - r >= 1) begin
            pkt_len = 8'd5;
            changed = 1;
         end
         cycle();
         n++;
      end
      hold_empty = 1'b0;
      ready = 1'b1;
      chk("sparse_drain", out_ptr, wr_ptr);
      cycle();
      chk("sparse_pkt_cnt", pkt_cnt, 16'd5);
      chk("sparse_model_cnt", pkt_cnt, exp_pkt[CNT_W-1:0]);
      chk("sparse_idle_valid", sif.o_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/afifo_rd_stream.md
Name: afifo_rd_stream

Overview:
Read-side consumer for the dual-clock FIFO. Runs entirely in the FIFO read clock domain. Drives the FIFO read port (rd_en, empty, gated data) and presents the words as a valid/ready stream, with optional fixed-length packet framing (last flag). A 2-entry registered skid buffer decouples downstream back-pressure from the FIFO read enable, so there is no combinational path from i_ready to o_fifo_rd_en.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
LEN_W, 8, width of the packet-length input.
CNT_W, 16, width of the completed-packet counter.

Ports:
i_clk  input  1  FIFO read clock.
i_rst  input  1  asynchronous reset, active-high.
i_enable  input  1  1 = fetch words from the FIFO; 0 = stop at the next packet boundary.
i_pkt_len  input  LEN_W  words per packet; 0 = unframed.
i_fifo_empty  input  1  FIFO empty flag.
o_fifo_rd_en  output  1  FIFO read enable.
i_fifo_data  input  WIDTH  FIFO read data; valid in the same cycle as o_fifo_rd_en & ~i_fifo_empty, and zero otherwise.
o_valid  output  1  stream data valid.
o_data  output  WIDTH  stream data.
o_last  output  1  marks the final word of a packet.
i_ready  input  1  downstream accepts.
o_busy  output  1  state != IDLE or the buffer is non-empty.
o_pkt_cnt  output  CNT_W  packets completed, wrapping.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - state = IDLE; buffer count = 0; word index = 0; latched length = 0; o_pkt_cnt = 0.
  - All outputs are 0 while reset is held and on the first cycle after release.
  - Reset mid-packet discards buffered words and the partial packet.
- Read issue:
  - o_fifo_rd_en = (state is RUN or FINISH) & ~i_fifo_empty & (count < 2).
  - This is registered-state logic only; it does not depend on i_ready.
- Push: when o_fifo_rd_en=1, i_fifo_data is written to the buffer tail in the same cycle, together with a last tag.
- Pop: when o_valid & i_ready, the head entry is removed.
  - Push and pop in the same cycle leave the count unchanged.
  - This sustains 1 word/cycle with count steady at 1.
- Stream outputs:
  - o_valid = (count != 0).
  - o_data and o_last come from the head entry, registered.
  - While o_valid=1 and i_ready=0, o_data and o_last stay stable.
  - Stream latency: a FIFO word pushed in cycle N is presented on o_data in cycle N+1.
- Framing:
  - At the push of word index 0, latch i_pkt_len into len_q. Changes to i_pkt_len mid-packet are ignored.
  - If len_q = 0: last tag = 0 and the index stays at 0.
  - Otherwise: last tag = (index == len_q-1). The index increments on each push and wraps to 0 after the last word.
  - len_q = 1 means every word is last.
- o_pkt_cnt increments by 1 on each pop whose last tag = 1, wrapping at 2^CNT_W.
- FSM:
  - IDLE: no reads. i_enable=1 -> RUN.
  - RUN: reads issued.
    - i_enable=0 and index=0 -> IDLE.
    - i_enable=0 and index!=0 -> FINISH.
  - FINISH: reads continue until the push carrying last=1, then -> IDLE. i_enable is ignored in FINISH.
  - Unframed mode (len_q=0): the index is always 0, so i_enable=0 stops reads on the next cycle.
- Empty FIFO: no read is issued; the FSM holds its state and the index.
- Buffer full (count=2): reads stall until a pop has reduced count below 2. The FIFO is never over-read.
- Buffered words are always delivered downstream, even after the FSM returns to IDLE.

Test Plan:
1. Reset & idle: assert i_rst mid-stream with count=2 -> o_valid=0, o_fifo_rd_en=0, o_pkt_cnt=0, o_busy=0; no reads while i_enable=0 and the FIFO holds data.
2. Streaming: i_pkt_len=0, i_ready=1, FIFO holds 0x01..0x10 -> 16 consecutive beats 0x01..0x10 starting 1 cycle after the first rd_en; o_last is always 0.
3. Framing: i_pkt_len=4, 12 words -> o_last on beats 4, 8 and 12; o_pkt_cnt=3. With i_pkt_len=1 -> every beat has last=1.
4. Back-pressure: i_ready=0 for 5 cycles -> exactly 2 reads are issued, then rd_en=0; o_data stays stable. On release -> no word is lost or duplicated.
5. Graceful stop: i_pkt_len=4, drop i_enable after word 2 is pushed -> FSM goes to FINISH, words 3-4 are read with last on word 4, then IDLE. Dropping i_enable at index 0 -> IDLE with no further reads.
6. Sparse source: toggle i_fifo_empty randomly -> the stream order matches the FIFO order, rd_en is never asserted while empty=1, and a len change mid-packet has no effect until the next packet.
